// File: rtl/ps2_zx_keyboard_if.sv
// PS/2 keyboard bus: the raw PS/2 lines and the ULA port-0xFE read path.
//   PS2_CLK, PS2_DAT : PS/2 lines from the keyboard (asynchronous)
//   A                : CPU address; A[15:8] are active-low row selects
//   KEYB             : active-low column result (0 = key pressed)
//   F1, F11          : held levels of the F1 / F11 keys
interface ps2_zx_keyboard_if;
  logic        PS2_CLK;
  logic        PS2_DAT;
  logic [15:0] A;
  logic [4:0]  KEYB;
  logic        F1;
  logic        F11;

  modport master (output PS2_CLK, PS2_DAT, A, input KEYB, F1, F11);
  modport slave  (input PS2_CLK, PS2_DAT, A, output KEYB, F1, F11);
endinterface

// File: rtl/ps2_zx_keyboard.sv
// PS/2 set-2 keyboard front end driving the ZX Spectrum 8x5 key matrix.
//   CLK    : ULA clock (14 MHz)
//   nRESET : asynchronous active-low reset
//   bus    : PS/2 lines in, CPU address in, KEYB / F1 / F11 out
module ps2_zx_keyboard #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 14000
) (
  input  logic               CLK,
  input  logic               nRESET,
  ps2_zx_keyboard_if.slave   bus
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          c_s1, c_s2, d_s1, d_s2;
  logic          c_f, c_f_d;
  logic [FW-1:0] f_cnt;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [10:0]   shreg;
  logic          done;
  logic          ext, brk;
  logic          lsh, rsh, bs, f1, f11;
  logic [7:0][4:0] mat;
  logic [7:0][4:0] eff;
  logic [4:0]    keyb_or;
  logic          fall_c;
  logic          frame_ok_c;
  logic [7:0]    byte_c;
  logic          hit;
  logic [2:0]    row, col;
  logic          unused_a_lo;

  assign unused_a_lo = ^bus.A[7:0];

  // Two-flop synchronisers; idle PS/2 lines are high
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      c_s1 <= 1'b1; c_s2 <= 1'b1;
      d_s1 <= 1'b1; d_s2 <= 1'b1;
    end else begin
      c_s1 <= bus.PS2_CLK; c_s2 <= c_s1;
      d_s1 <= bus.PS2_DAT; d_s2 <= d_s1;
    end
  end

  // Glitch filter: the clock level flips after FILTER_LEN consecutive differing samples
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      c_f   <= 1'b1;
      c_f_d <= 1'b1;
      f_cnt <= '0;
    end else begin
      c_f_d <= c_f;
      if (c_s2 == c_f) begin
        f_cnt <= '0;
      end else if (f_cnt == FW'(FILTER_LEN - 1)) begin
        c_f   <= c_s2;
        f_cnt <= '0;
      end else begin
        f_cnt <= f_cnt + 1'b1;
      end
    end
  end

  assign fall_c = c_f_d & ~c_f;

  // Frame deserialiser with mid-frame idle timeout; a falling edge always beats the timeout
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      bit_cnt <= '0;
      to_cnt  <= '0;
      shreg   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (fall_c) begin
        shreg[bit_cnt] <= d_s2;
        to_cnt         <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          done    <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt <= '0;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  assign frame_ok_c = done & ~shreg[0] & shreg[10] & (^shreg[9:1]);
  assign byte_c     = shreg[8:1];

  // Scan code to matrix position for ordinary keys; shifts and aux keys are handled separately
  always_comb begin
    hit = 1'b1;
    row = 3'd0;
    col = 3'd0;
    case (byte_c)
      8'h1A: begin row = 3'd0; col = 3'd1; end
      8'h22: begin row = 3'd0; col = 3'd2; end
      8'h21: begin row = 3'd0; col = 3'd3; end
      8'h2A: begin row = 3'd0; col = 3'd4; end
      8'h1C: begin row = 3'd1; col = 3'd0; end
      8'h1B: begin row = 3'd1; col = 3'd1; end
      8'h23: begin row = 3'd1; col = 3'd2; end
      8'h2B: begin row = 3'd1; col = 3'd3; end
      8'h34: begin row = 3'd1; col = 3'd4; end
      8'h15: begin row = 3'd2; col = 3'd0; end
      8'h1D: begin row = 3'd2; col = 3'd1; end
      8'h24: begin row = 3'd2; col = 3'd2; end
      8'h2D: begin row = 3'd2; col = 3'd3; end
      8'h2C: begin row = 3'd2; col = 3'd4; end
      8'h16: begin row = 3'd3; col = 3'd0; end
      8'h1E: begin row = 3'd3; col = 3'd1; end
      8'h26: begin row = 3'd3; col = 3'd2; end
      8'h25: begin row = 3'd3; col = 3'd3; end
      8'h2E: begin row = 3'd3; col = 3'd4; end
      8'h45: begin row = 3'd4; col = 3'd0; end
      8'h46: begin row = 3'd4; col = 3'd1; end
      8'h3E: begin row = 3'd4; col = 3'd2; end
      8'h3D: begin row = 3'd4; col = 3'd3; end
      8'h36: begin row = 3'd4; col = 3'd4; end
      8'h4D: begin row = 3'd5; col = 3'd0; end
      8'h44: begin row = 3'd5; col = 3'd1; end
      8'h43: begin row = 3'd5; col = 3'd2; end
      8'h3C: begin row = 3'd5; col = 3'd3; end
      8'h35: begin row = 3'd5; col = 3'd4; end
      8'h5A: begin row = 3'd6; col = 3'd0; end
      8'h4B: begin row = 3'd6; col = 3'd1; end
      8'h42: begin row = 3'd6; col = 3'd2; end
      8'h3B: begin row = 3'd6; col = 3'd3; end
      8'h33: begin row = 3'd6; col = 3'd4; end
      8'h29: begin row = 3'd7; col = 3'd0; end
      8'h14: begin row = 3'd7; col = 3'd1; end
      8'h3A: begin row = 3'd7; col = 3'd2; end
      8'h31: begin row = 3'd7; col = 3'd3; end
      8'h32: begin row = 3'd7; col = 3'd4; end
      default: hit = 1'b0;
    endcase
  end

  // Make/break decoder; E0-prefixed shift codes are the keyboard's fake shifts and are dropped
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      ext <= 1'b0; brk <= 1'b0;
      lsh <= 1'b0; rsh <= 1'b0; bs <= 1'b0;
      f1  <= 1'b0; f11 <= 1'b0;
      mat <= '0;
    end else if (frame_ok_c) begin
      case (byte_c)
        8'hE0: ext <= 1'b1;
        8'hF0: brk <= 1'b1;
        8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'h00: ;
        default: begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (!(ext && (byte_c == 8'h12 || byte_c == 8'h59))) begin
            case (byte_c)
              8'h12:   lsh <= ~brk;
              8'h59:   rsh <= ~brk;
              8'h66:   bs  <= ~brk;
              8'h05:   f1  <= ~brk;
              8'h78:   f11 <= ~brk;
              default: if (hit) mat[row][col] <= ~brk;
            endcase
          end
        end
      endcase
    end
  end

  // Backspace presses CS+0 on top of whatever is physically held
  always_comb begin
    eff       = mat;
    eff[0][0] = mat[0][0] | lsh | rsh | bs;
    eff[4][0] = mat[4][0] | bs;
    keyb_or   = '0;
    for (int r = 0; r < 8; r++) begin
      if (!bus.A[8+r]) keyb_or = keyb_or | eff[r];
    end
  end

  assign bus.KEYB = ~keyb_or;
  assign bus.F1   = f1;
  assign bus.F11  = f11;

endmodule

// File: tb/tb_ps2_zx_keyboard.sv
// Scoreboard bench for ps2_zx_keyboard: directed PS/2 frames, expected port-0xFE reads queued.
module tb_ps2_zx_keyboard;

  typedef struct {
    logic [15:0] a;
    logic [4:0]  keyb;
    logic        f1;
    logic        f11;
    string       name;
  } exp_t;

  logic CLK;
  logic nRESET;
  int   compared;
  int   mism;
  exp_t q[$];

  ps2_zx_keyboard_if bus();

  ps2_zx_keyboard #(.FILTER_LEN(8), .TIMEOUT_CYCLES(14000)) dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLK);
  endtask

  // Drive the first nbits of a frame; bad_par flips the parity bit
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    logic        par;
    par = (~^b) ^ bad_par;
    fr  = {1'b1, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.PS2_DAT = fr[i];
      wait_clk(10);
      bus.PS2_CLK = 1'b0;
      wait_clk(20);
      bus.PS2_CLK = 1'b1;
      wait_clk(10);
    end
    bus.PS2_DAT = 1'b1;
    wait_clk(30);
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(b, 1'b0, 11);
  endtask

  // Apply an address, queue the expected response and wait for the monitor to consume it
  task automatic expect_k(input logic [15:0] a, input logic [4:0] k,
                          input logic ef1, input logic ef11, input string nm);
    exp_t e;
    int   n;
    @(posedge CLK);
    bus.A  = a;
    e.a    = a;
    e.keyb = k;
    e.f1   = ef1;
    e.f11  = ef11;
    e.name = nm;
    q.push_back(e);
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge CLK);
      n++;
    end
    if (q.size() != 0) begin
      $display("FAIL %s: monitor did not consume expectation within 20 cycles", nm);
      compared++;
      mism++;
      q.delete();
    end
  endtask

  // Monitor: compare the DUT outputs against the head of the queue on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() != 0) begin
        e = q.pop_front();
        compared++;
        if (bus.KEYB !== e.keyb || bus.F1 !== e.f1 || bus.F11 !== e.f11) begin
          mism++;
          $display("FAIL %s: A=%h got KEYB=%b F1=%b F11=%b, required KEYB=%b F1=%b F11=%b",
                   e.name, e.a, bus.KEYB, bus.F1, bus.F11, e.keyb, e.f1, e.f11);
        end
      end
    end
  end

  initial begin
    compared    = 0;
    mism        = 0;
    nRESET      = 1'b0;
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    bus.A       = 16'hFFFF;
    wait_clk(5);
    nRESET = 1'b1;
    wait_clk(5);

    expect_k(16'h00FE, 5'b11111, 1'b0, 1'b0, "reset_all_rows");
    expect_k(16'hFFFE, 5'b11111, 1'b0, 1'b0, "reset_no_row");

    // A press and release
    send(8'h1C);
    expect_k(16'hFDFE, 5'b11110, 1'b0, 1'b0, "a_make");
    expect_k(16'hFEFE, 5'b11111, 1'b0, 1'b0, "a_other_row");
    send(8'hF0); send(8'h1C);
    expect_k(16'hFDFE, 5'b11111, 1'b0, 1'b0, "a_break");

    // Left shift + X on row 0
    send(8'h12); send(8'h22);
    expect_k(16'hFEFE, 5'b11010, 1'b0, 1'b0, "cs_x_row0");
    expect_k(16'h7FFE, 5'b11111, 1'b0, 1'b0, "cs_x_row7");
    expect_k(16'h00FE, 5'b11010, 1'b0, 1'b0, "cs_x_all_rows");
    send(8'hF0); send(8'h12);
    send(8'hF0); send(8'h22);
    expect_k(16'h00FE, 5'b11111, 1'b0, 1'b0, "cs_x_released");

    // Extended codes
    send(8'hE0); send(8'h5A);
    expect_k(16'hBFFE, 5'b11110, 1'b0, 1'b0, "e0_enter");
    send(8'hE0); send(8'h12);
    expect_k(16'hFEFE, 5'b11111, 1'b0, 1'b0, "fake_shift_ignored");
    send(8'hE0); send(8'hF0); send(8'h5A);
    expect_k(16'hBFFE, 5'b11111, 1'b0, 1'b0, "e0_enter_break");
    send(8'hE0); send(8'h14);
    expect_k(16'h7FFE, 5'b11101, 1'b0, 1'b0, "e0_ss");
    send(8'hE0); send(8'hF0); send(8'h14);
    expect_k(16'h7FFE, 5'b11111, 1'b0, 1'b0, "e0_ss_break");

    // Backspace overlays CS and 0 without disturbing a held shift
    send(8'h12);
    expect_k(16'hFEFE, 5'b11110, 1'b0, 1'b0, "shift_row0");
    expect_k(16'hEFFE, 5'b11111, 1'b0, 1'b0, "shift_row4");
    send(8'h66);
    expect_k(16'hFEFE, 5'b11110, 1'b0, 1'b0, "bs_row0");
    expect_k(16'hEFFE, 5'b11110, 1'b0, 1'b0, "bs_row4");
    send(8'h66);
    expect_k(16'hEFFE, 5'b11110, 1'b0, 1'b0, "bs_repeat");
    send(8'hF0); send(8'h66);
    expect_k(16'hFEFE, 5'b11110, 1'b0, 1'b0, "bs_break_shift_held");
    expect_k(16'hEFFE, 5'b11111, 1'b0, 1'b0, "bs_break_row4");
    send(8'hF0); send(8'h12);
    expect_k(16'hFEFE, 5'b11111, 1'b0, 1'b0, "shift_break");
    send(8'hF0); send(8'h1A);
    expect_k(16'hFEFE, 5'b11111, 1'b0, 1'b0, "break_unpressed");

    // Bad parity and timeout recovery
    send_bits(8'h1C, 1'b1, 11);
    expect_k(16'hFDFE, 5'b11111, 1'b0, 1'b0, "bad_parity");
    send_bits(8'h1C, 1'b0, 5);
    expect_k(16'hFDFE, 5'b11111, 1'b0, 1'b0, "partial_frame");
    wait_clk(14100);
    send(8'h15);
    expect_k(16'hFBFE, 5'b11110, 1'b0, 1'b0, "q_after_timeout");

    // F1 / F11 levels
    send(8'h05);
    expect_k(16'hFFFE, 5'b11111, 1'b1, 1'b0, "f1_make");
    send(8'h78);
    expect_k(16'hFFFE, 5'b11111, 1'b1, 1'b1, "f11_make");
    send(8'hF0); send(8'h05);
    expect_k(16'hFBFE, 5'b11110, 1'b0, 1'b1, "f1_break");

    // Reset in mid-frame
    send_bits(8'h1C, 1'b0, 4);
    nRESET = 1'b0;
    wait_clk(3);
    nRESET = 1'b1;
    wait_clk(3);
    expect_k(16'h00FE, 5'b11111, 1'b0, 1'b0, "mid_frame_reset");
    send(8'h1C);
    expect_k(16'hFDFE, 5'b11110, 1'b0, 1'b0, "after_reset_a");

    wait_clk(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
